// File: rtl/lock_pkg.sv
// Shared definitions for the six-digit lock datapath.
// Contents:
//   lock_state_t        supervisor state encoding (3 is illegal)
//   *_DEF localparams   default supervisor parameters
//   FAIL_W              width of the consecutive-failure counter
package lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } lock_state_t;

    localparam int unsigned MAX_FAIL_DEF       = 3;
    localparam int unsigned UNLOCK_CYCLES_DEF  = 8;
    localparam int unsigned LOCKOUT_CYCLES_DEF = 16;
    localparam int unsigned TW_DEF             = 8;
    localparam int unsigned FAIL_W             = 4;

endpackage

// File: rtl/edge_detect_rise.sv
// Single-bit rising-edge detector.
// Ports:
//   clk     system clock, rising edge
//   clr     asynchronous active-high reset
//   sig     level input (button or strobe)
//   rise_c  combinational one-cycle pulse on a 0->1 transition of sig
// The delayed copy resets to 0, so a sig already high at reset release
// produces a pulse in the first cycle.
module edge_detect_rise (
    input  logic clk,
    input  logic clr,
    input  logic sig,
    output logic rise_c
);

    logic sig_d;

    // Previous-cycle copy of the input
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    assign rise_c = sig & ~sig_d;

endmodule

// File: rtl/lock_attempt_supervisor.sv
// Attempt supervisor for the six-digit lock: turns judge/match into a timed
// unlock pulse, counts consecutive failures and enforces a timed lockout.
// Ports:
//   clk      system clock, rising edge
//   clr      asynchronous active-high reset
//   judge    attempt request level; an attempt is its rising edge
//   match    compare result, sampled in the attempt cycle
//   relock   force early relock while unlocked
//   unlock   bolt open
//   lockout  attempts blocked
//   alarm    alarm buzzer, same as lockout
//   fail_cnt consecutive failures so far
//   timer    remaining cycles in UNLOCKED/LOCKOUT, 0 in IDLE
//   state    IDLE=0, UNLOCKED=1, LOCKOUT=2
module lock_attempt_supervisor
    import lock_pkg::*;
#(
    parameter int unsigned MAX_FAIL       = MAX_FAIL_DEF,
    parameter int unsigned UNLOCK_CYCLES  = UNLOCK_CYCLES_DEF,
    parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
    parameter int unsigned TW             = TW_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              judge,
    input  logic              match,
    input  logic              relock,
    output logic              unlock,
    output logic              lockout,
    output logic              alarm,
    output logic [FAIL_W-1:0] fail_cnt,
    output logic [TW-1:0]     timer,
    output logic [1:0]        state
);

    localparam logic [TW-1:0]     UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0]     LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT   = FAIL_W'(MAX_FAIL);

    logic attempt;

    edge_detect_rise u_judge_edge (
        .clk    (clk),
        .clr    (clr),
        .sig    (judge),
        .rise_c (attempt)
    );

    // Supervisor FSM; status outputs are loaded alongside the state so they
    // are true flops that follow the state register exactly.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= ST_IDLE;
            timer    <= '0;
            fail_cnt <= '0;
            unlock   <= 1'b0;
            lockout  <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (attempt && match) begin
                        state    <= ST_UNLOCKED;
                        timer    <= UNLOCK_LOAD;
                        fail_cnt <= '0;
                        unlock   <= 1'b1;
                    end else if (attempt && (fail_cnt + FAIL_W'(1) == FAIL_LIMIT)) begin
                        state    <= ST_LOCKOUT;
                        timer    <= LOCKOUT_LOAD;
                        fail_cnt <= FAIL_LIMIT;
                        lockout  <= 1'b1;
                        alarm    <= 1'b1;
                    end else if (attempt) begin
                        fail_cnt <= fail_cnt + FAIL_W'(1);
                    end
                end

                ST_UNLOCKED: begin
                    // Early relock wins over natural expiry; both end in IDLE.
                    if (relock || (timer == '0)) begin
                        state  <= ST_IDLE;
                        timer  <= '0;
                        unlock <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                ST_LOCKOUT: begin
                    // Attempts and relock have no effect until the timer runs out.
                    if (timer == '0) begin
                        state    <= ST_IDLE;
                        fail_cnt <= '0;
                        lockout  <= 1'b0;
                        alarm    <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                default: begin
                    // Illegal encoding: recover to reset values.
                    state    <= ST_IDLE;
                    timer    <= '0;
                    fail_cnt <= '0;
                    unlock   <= 1'b0;
                    lockout  <= 1'b0;
                    alarm    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_attempt_supervisor.sv
// Self-checking bench for lock_attempt_supervisor (default parameters).
module tb_lock_attempt_supervisor;

    logic       clk;
    logic       clr;
    logic       judge;
    logic       match;
    logic       relock;
    logic       unlock;
    logic       lockout;
    logic       alarm;
    logic [3:0] fail_cnt;
    logic [7:0] timer;
    logic [1:0] state;

    int n_chk;
    int n_pass;

    typedef struct {
        logic       judge;
        logic       match;
        logic       relock;
        logic       unl;
        logic       lo;
        logic [3:0] fc;
        logic [7:0] tm;
        logic [1:0] st;
    } vec_t;

    vec_t vq[$];

    lock_attempt_supervisor dut (
        .clk      (clk),
        .clr      (clr),
        .judge    (judge),
        .match    (match),
        .relock   (relock),
        .unlock   (unlock),
        .lockout  (lockout),
        .alarm    (alarm),
        .fail_cnt (fail_cnt),
        .timer    (timer),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic j, input logic m, input logic r,
                       input logic unl, input logic lo, input int fc,
                       input int tm, input int st);
        vec_t v;
        v.judge  = j;
        v.match  = m;
        v.relock = r;
        v.unl    = unl;
        v.lo     = lo;
        v.fc     = 4'(fc);
        v.tm     = 8'(tm);
        v.st     = 2'(st);
        vq.push_back(v);
    endtask

    task automatic check_out(input string name, input logic unl, input logic lo,
                             input logic [3:0] fc, input logic [7:0] tm,
                             input logic [1:0] st);
        n_chk++;
        if (unlock === unl && lockout === lo && alarm === lo &&
            fail_cnt === fc && timer === tm && state === st) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got unlock=%b lockout=%b alarm=%b fail_cnt=%0d timer=%0d state=%0d, want unlock=%b lockout=%b alarm=%b fail_cnt=%0d timer=%0d state=%0d",
                     name, unlock, lockout, alarm, fail_cnt, timer, state,
                     unl, lo, lo, fc, tm, st);
        end
    endtask

    // Drive inputs, clock once, check just after the edge.
    task automatic cyc(input logic j, input logic m, input logic r);
        judge  = j;
        match  = m;
        relock = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        clr    = 1'b1;
        judge  = 1'b0;
        match  = 1'b0;
        relock = 1'b0;

        // Successful attempt after a few idle cycles; unlock for 8 cycles.
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 7, 1);
        for (int t = 6; t >= 0; t--) add(0, 0, 0, 1, 0, 0, t, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // Three failures -> 16-cycle lockout; judge pulses and relock ignored.
        add(1, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0, 0, 2, 0, 0);
        add(1, 0, 0, 0, 1, 3, 15, 2);
        for (int k = 14; k >= 0; k--) add(logic'(k % 2), 0, 1, 0, 1, 3, k, 2);
        // Attempt edge on the expiry cycle is dropped.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // Two failures, success clears count, relock at unlock cycle 3.
        add(1, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0, 0, 2, 0, 0);
        add(1, 1, 0, 1, 0, 0, 7, 1);
        add(0, 0, 0, 1, 0, 0, 6, 1);
        add(0, 0, 0, 1, 0, 0, 5, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        // Two further failures stop at 2, no lockout.
        add(1, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0, 0, 2, 0, 0);
        add(0, 0, 0, 0, 0, 2, 0, 0);
        // Clear count via success + relock, then hold judge 20 cycles.
        add(1, 1, 0, 1, 0, 0, 7, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) add(1, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0);

        #2;
        check_out("reset", 0, 0, 4'd0, 8'd0, 2'd0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].judge, vq[i].match, vq[i].relock);
            check_out($sformatf("vec%0d", i), vq[i].unl, vq[i].lo,
                      vq[i].fc, vq[i].tm, vq[i].st);
        end

        // Reach lockout from fail_cnt=1, then clear asynchronously at timer=9.
        cyc(1, 0, 0);
        check_out("pre_lock_fail2", 0, 0, 4'd2, 8'd0, 2'd0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        check_out("lock_enter", 0, 1, 4'd3, 8'd15, 2'd2);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0);
        check_out("lock_timer9", 0, 1, 4'd3, 8'd9, 2'd2);
        #2;
        clr   = 1'b1;
        judge = 1'b1;
        match = 1'b1;
        #1;
        check_out("async_clr", 0, 0, 4'd0, 8'd0, 2'd0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        check_out("unlock_after_clr", 1, 0, 4'd0, 8'd7, 2'd1);
        cyc(1, 1, 0);
        check_out("unlock_held_judge", 1, 0, 4'd0, 8'd6, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
